// File: rtl/pipe_adder.sv
// Purpose: add/subtract unit with the carry chain split into STAGES registered segments.
// Latency: STAGES cycles from accept to out_valid; one beat per cycle sustained.
// Backpressure: valid/ready; stalled stages hold and bubbles collapse, in_ready drops only when stage 0 is full and cannot advance.
module pipe_adder #(
    parameter int WIDTH         = 16,
    parameter int STAGES        = 4,
    parameter int ACTIVE_LOW_IN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Board switches may be active-low; fold the inversion in before any arithmetic.
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    assign a_eff   = (ACTIVE_LOW_IN != 0) ? ~a   : a;
    assign b_eff   = (ACTIVE_LOW_IN != 0) ? ~b   : b;
    assign cin_eff = (ACTIVE_LOW_IN != 0) ? ~cin : cin;

    // Per-stage state: partial result, carry into the next segment, and the
    // operands/mode delayed so later stages can finish the upper segments.
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [STAGES-1:0] cy_q;
    logic [STAGES-1:0] mode_q;

    // ld[k]: stage k captures this cycle; ld[STAGES] is the downstream ready.
    logic [STAGES:0] ld;

    // A stage loads when empty or when everything after it moves (bubble collapse).
    always_comb begin
        ld         = '0;
        ld[STAGES] = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            ld[k] = !vld[k] || ld[k+1];
        end
    end

    assign in_ready = ld[0] && !rst;

    // Inputs seen by each stage: the port operands for stage 0, the previous stage otherwise.
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_r [STAGES];
    logic [WIDTH-1:0]  nxt_r [STAGES];
    logic [STAGES-1:0] src_m;
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] nxt_c;
    logic [SEG-1:0]    bseg;
    logic [SEG:0]      seg;

    // One SEG-wide add per stage; the carry never ripples past a segment boundary combinationally.
    always_comb begin
        bseg  = '0;
        seg   = '0;
        src_m = '0;
        src_c = '0;
        nxt_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            src_a[k] = '0;
            src_b[k] = '0;
            src_r[k] = '0;
            nxt_r[k] = '0;
        end
        // In subtract mode the borrow-in is inverted to form a + ~b + ~cin.
        src_a[0] = a_eff;
        src_b[0] = b_eff;
        src_m[0] = mode;
        src_c[0] = cin_eff ^ mode;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = opa_q[k-1];
            src_b[k] = opb_q[k-1];
            src_r[k] = res_q[k-1];
            src_m[k] = mode_q[k-1];
            src_c[k] = cy_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            bseg     = src_m[k] ? ~src_b[k][k*SEG +: SEG] : src_b[k][k*SEG +: SEG];
            seg      = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, bseg} + {{SEG{1'b0}}, src_c[k]};
            nxt_r[k] = src_r[k];
            nxt_r[k][k*SEG +: SEG] = seg[SEG-1:0];
            nxt_c[k] = seg[SEG];
        end
    end

    // Pipeline registers; a stalled stage keeps its contents so the output stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld    <= '0;
            cy_q   <= '0;
            mode_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else begin
            if (ld[0]) vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) vld[k] <= vld[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    res_q[k]  <= nxt_r[k];
                    cy_q[k]   <= nxt_c[k];
                    opa_q[k]  <= src_a[k];
                    opb_q[k]  <= src_b[k];
                    mode_q[k] <= src_m[k];
                end
            end
        end
    end

    assign out_valid = vld[LAST];
    assign sum       = res_q[LAST];
    assign cout      = cy_q[LAST];

    // Signed overflow from the last stage's registered operand/result MSBs; all-zero after reset gives 0.
    logic bmsb_eff;
    assign bmsb_eff = mode_q[LAST] ^ opb_q[LAST][WIDTH-1];
    assign ovf      = (opa_q[LAST][WIDTH-1] == bmsb_eff) &&
                      (res_q[LAST][WIDTH-1] != opa_q[LAST][WIDTH-1]);

endmodule
